// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the register-file write path.
// Provides the register-address/data widths and the writeback request
// record {dest, val} used by the write arbiter and its load buffer.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     val;
  } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of every non-clock signal of the register-file write arbiter.
//   ALU writeback  : a_valid, a_dest, a_val -> a_ready
//   Load return    : b_valid, b_dest, b_val -> b_ready
//   Hazard check   : ld_issue, ld_dest, src1, src2 -> src1_busy, src2_busy
//   RF write port  : rf_we, rf_dest, rf_val
// master = pipeline side driving requests, slave = the arbiter.
interface rf_write_arbiter_if;
  import mips_pkg::*;

  logic                  a_valid;
  logic [REG_ADDR_W-1:0] a_dest;
  logic [DATA_W-1:0]     a_val;
  logic                  a_ready;

  logic                  b_valid;
  logic [REG_ADDR_W-1:0] b_dest;
  logic [DATA_W-1:0]     b_val;
  logic                  b_ready;

  logic                  ld_issue;
  logic [REG_ADDR_W-1:0] ld_dest;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  src1_busy;
  logic                  src2_busy;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0]     rf_val;

  modport master (
    output a_valid, a_dest, a_val, b_valid, b_dest, b_val,
           ld_issue, ld_dest, src1, src2,
    input  a_ready, b_ready, src1_busy, src2_busy, rf_we, rf_dest, rf_val
  );

  modport slave (
    input  a_valid, a_dest, a_val, b_valid, b_dest, b_val,
           ld_issue, ld_dest, src1, src2,
    output a_ready, b_ready, src1_busy, src2_busy, rf_we, rf_dest, rf_val
  );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO holding load returns waiting for the register-file write port.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write push_data_i at the tail (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   head_o       : current head entry, combinational from storage
//   count_o      : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  wb_req_t        push_data_i,
  input  logic           pop_i,
  output wb_req_t        head_o,
  output logic [PTR_W:0] count_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;

  // Push and pop in the same cycle leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback (A)
// and SRAM load returns (B), and tracks registers awaiting a pending load.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_write_arbiter_if.slave (A/B requests, hazard check, RF port)
// Parameters:
//   DEPTH        : load-return buffer entries (power of two, >= 2)
//   STARVE_LIMIT : cycles a buffered load waits before preempting A
// Load returns are always buffered first (no pass-through), so a load is
// written one cycle after acceptance at the earliest. A wins the port
// unless the buffer head has waited STARVE_LIMIT cycles.
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  rf_write_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

  wb_req_t           push_data;
  wb_req_t           head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              grant_a;
  logic              grant_b;
  logic [AGE_W-1:0]  age_q;
  logic [AGE_W-1:0]  age_d;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  assign push_data = '{dest: bus.b_dest, val: bus.b_val};

  wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);

  // Readiness looks only at the current occupancy, never at a same-cycle pop.
  assign bus.b_ready = !rst && (fifo_count < FULL_CNT);
  assign push        = bus.b_valid && bus.b_ready;

  assign grant_b = !rst && !fifo_empty && (!bus.a_valid || age_q >= AGE_MAX);
  assign grant_a = !rst && bus.a_valid && !grant_b;
  assign pop     = grant_b;

  assign bus.a_ready = !rst && !(grant_b && bus.a_valid);

  // Register 0 is hardwired: its requests complete but never write.
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_dest = '0;
    bus.rf_val  = '0;
    if (grant_b) begin
      bus.rf_dest = head.dest;
      bus.rf_val  = head.val;
      bus.rf_we   = (head.dest != '0);
    end else if (grant_a) begin
      bus.rf_dest = bus.a_dest;
      bus.rf_val  = bus.a_val;
      bus.rf_we   = (bus.a_dest != '0);
    end
  end

  // Age of the current head; restarts whenever a new entry becomes head.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q < AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
  end

  // Busy bit per register: a new issue wins over a same-cycle clear.
  assign busy_d[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
    assign busy_d[gi] =
        (bus.ld_issue && bus.ld_dest == REG_ADDR_W'(gi)) ||
        (busy_q[gi] && !(pop && head.dest == REG_ADDR_W'(gi)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q  <= '0;
      busy_q <= '0;
    end else begin
      age_q  <= age_d;
      busy_q <= busy_d;
    end
  end

  assign bus.src1_busy = !rst && busy_q[bus.src1] && (bus.src1 != '0);
  assign bus.src2_busy = !rst && busy_q[bus.src2] && (bus.src2 != '0);

  // The pipeline must stall rather than re-issue a load to a pending register.
  a_no_reissue_busy: assert property (@(posedge clk) disable iff (rst)
    (bus.ld_issue && bus.ld_dest != '0) |-> !busy_q[bus.ld_dest]);

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import mips_pkg::*;

  typedef struct {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     val;
    int                    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // Full-buffer scenario table (one row per cycle), dest 0 = no write.
  logic [REG_ADDR_W-1:0] fb_dest [9] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd10, 5'd11, 5'd12, 5'd0};
  logic [DATA_W-1:0]     fb_val  [9] = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44,
                                         32'h10A, 32'h10B, 32'h10C, 32'h0};
  logic                  fb_brdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_wr(input logic [REG_ADDR_W-1:0] dest, input logic [DATA_W-1:0] val,
                           input int at_cyc);
    exp_t e;
    if (dest != '0) begin
      e.dest = dest;
      e.val  = val;
      e.cyc  = at_cyc;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every RF write must match the next expected write, in its cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_write: got no write in cyc %0d, required dest=%0d val=0x%0h",
               e.cyc, e.dest, e.val);
    end
    if (bus.rf_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL unexpected_write: got dest=%0d val=0x%0h in cyc %0d, required no write",
                 bus.rf_dest, bus.rf_val, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_dest !== e.dest || bus.rf_val !== e.val) begin
          n_fail++;
          $display("FAIL write_data: got dest=%0d val=0x%0h, required dest=%0d val=0x%0h (cyc %0d)",
                   bus.rf_dest, bus.rf_val, e.dest, e.val, cyc);
        end else begin
          $display("[TB] write cyc=%0d dest=%0d val=0x%0h", cyc, bus.rf_dest, bus.rf_val);
        end
      end
    end
  end

  initial begin
    bus.a_valid  = 1'b0; bus.a_dest = '0; bus.a_val = '0;
    bus.b_valid  = 1'b0; bus.b_dest = '0; bus.b_val = '0;
    bus.ld_issue = 1'b0; bus.ld_dest = '0;
    bus.src1     = '0;   bus.src2 = '0;
    rst = 1'b1;
    tick();

    // Reset forces all handshake/hazard outputs low even with requests up.
    bus.a_valid = 1'b1; bus.a_dest = 5'd5; bus.b_valid = 1'b1; bus.b_dest = 5'd3;
    bus.src1 = 5'd5; bus.src2 = 5'd3;
    sample();
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_src1_busy", bus.src1_busy, 0);
    chk("rst_src2_busy", bus.src2_busy, 0);
    tick();
    rst = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    sample();
    chk("post_rst_b_ready", bus.b_ready, 1);
    chk("post_rst_src1_busy", bus.src1_busy, 0);
    tick();

    // A alone: same-cycle write.
    bus.a_valid = 1'b1; bus.a_dest = 5'd5; bus.a_val = 32'hDEAD;
    expect_wr(5'd5, 32'hDEAD, cyc);
    sample();
    chk("a_alone_a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;

    // B while idle: issue load to r7, return it, written one cycle later.
    bus.ld_issue = 1'b1; bus.ld_dest = 5'd7; bus.src1 = 5'd7;
    sample();
    chk("ld7_busy_not_yet", bus.src1_busy, 0);
    tick();
    bus.ld_issue = 1'b0;
    bus.b_valid = 1'b1; bus.b_dest = 5'd7; bus.b_val = 32'h1234;
    expect_wr(5'd7, 32'h1234, cyc + 1);
    sample();
    chk("ld7_busy_pending", bus.src1_busy, 1);
    chk("ld7_b_ready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    sample();
    chk("ld7_busy_write_cycle", bus.src1_busy, 1);
    tick();
    sample();
    chk("ld7_busy_cleared", bus.src1_busy, 0);
    tick();

    // Starvation: A held continuously, one buffered load preempts at age 4.
    bus.ld_issue = 1'b1; bus.ld_dest = 5'd9; bus.src2 = 5'd9;
    tick();
    bus.ld_issue = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.a_valid = 1'b1; bus.a_dest = 5'd3; bus.a_val = 32'hA0 + i;
      bus.b_valid = (i == 0); bus.b_dest = 5'd9; bus.b_val = 32'h9999;
      if (i == 5) expect_wr(5'd9, 32'h9999, cyc);
      else        expect_wr(5'd3, 32'hA0 + i, cyc);
      sample();
      chk($sformatf("starve_a_ready_%0d", i), bus.a_ready, (i == 5) ? 0 : 1);
      if (i == 5) chk("starve_src2_busy_at_pop", bus.src2_busy, 1);
      if (i == 6) chk("starve_src2_busy_after", bus.src2_busy, 0);
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    // Full buffer: two loads buffered behind A, third held until space frees;
    // then a push and pop in the same cycle.
    for (int i = 0; i < 9; i++) begin
      bus.a_valid = (i <= 5); bus.a_dest = 5'd4; bus.a_val = 32'h40 + i;
      bus.b_valid = (i <= 6);
      bus.b_dest  = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
      bus.b_val   = 32'h100 + 32'(bus.b_dest);
      expect_wr(fb_dest[i], fb_val[i], cyc);
      sample();
      if (i <= 6) chk($sformatf("full_b_ready_%0d", i), bus.b_ready, 32'(fb_brdy[i]));
      if (i <= 7) chk($sformatf("full_a_ready_%0d", i), bus.a_ready, (i == 5) ? 0 : 1);
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    // Register 0: handshakes complete, nothing written, never busy.
    bus.a_valid = 1'b1; bus.a_dest = 5'd0; bus.a_val = 32'h55;
    sample();
    chk("dest0_a_ready", bus.a_ready, 1);
    chk("dest0_a_rf_we", bus.rf_we, 0);
    tick();
    bus.a_valid = 1'b0;
    bus.ld_issue = 1'b1; bus.ld_dest = 5'd0; bus.src1 = 5'd0;
    tick();
    bus.ld_issue = 1'b0;
    bus.b_valid = 1'b1; bus.b_dest = 5'd0; bus.b_val = 32'h66;
    sample();
    chk("dest0_src1_busy", bus.src1_busy, 0);
    chk("dest0_b_ready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    sample();
    chk("dest0_b_rf_we", bus.rf_we, 0);
    tick();

    // Mid-operation reset with two loads buffered.
    bus.ld_issue = 1'b1; bus.ld_dest = 5'd20;
    tick();
    bus.ld_dest = 5'd21;
    tick();
    bus.ld_issue = 1'b0; bus.src1 = 5'd20; bus.src2 = 5'd21;
    for (int i = 0; i < 2; i++) begin
      bus.a_valid = 1'b1; bus.a_dest = 5'd2; bus.a_val = 32'h200 + i;
      bus.b_valid = 1'b1; bus.b_dest = 5'(20 + i); bus.b_val = 32'h2000 + i;
      expect_wr(5'd2, 32'h200 + i, cyc);
      sample();
      chk($sformatf("mid_b_ready_%0d", i), bus.b_ready, 1);
      if (i == 1) chk("mid_src1_busy_before", bus.src1_busy, 1);
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    rst = 1'b1;
    sample();
    chk("mid_rst_rf_we", bus.rf_we, 0);
    tick();
    rst = 1'b0;
    sample();
    chk("mid_post_b_ready", bus.b_ready, 1);
    chk("mid_post_src1_busy", bus.src1_busy, 0);
    chk("mid_post_src2_busy", bus.src2_busy, 0);
    tick();
    sample();
    chk("mid_post_rf_we", bus.rf_we, 0);
    tick();
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
